// File: rtl/pool_max_1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : lenet_pkg                                                        |
// | Purpose : Constants and types shared by the first-layer LeNet pooling path |
// |           and its neighbours (relu_1 may reference POOL_LAT).              |
// | Contents: DW, LANES, WIN, POOL_LAT, sample_t                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package lenet_pkg;

  localparam int DW       = 16;  // sample width, signed two's complement
  localparam int LANES    = 10;  // output words per beat
  localparam int WIN      = 4;   // samples per 2x2 pooling window
  localparam int POOL_LAT = 3;   // max_en -> pool_max_vld latency in cycles

  typedef logic signed [DW-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/pool_max_1_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: pool_max_1_if                                                   |
// | Purpose  : Beat input and pooled result bundle between relu_1 (master)     |
// |            and pool_max_1 (slave).                                         |
// | Signals  : max_en          beat valid, row data valid in the same cycle    |
// |            fm_bram_1_douta LANES*WIN*DW row from fm_bram_1                 |
// |            pool_max_result LANES*DW pooled words                           |
// |            pool_max_vld    one-cycle strobe for a new result               |
// |            pool_max_cnt    saturating count of results since reset         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pool_max_1_if #(
  parameter int DW    = lenet_pkg::DW,
  parameter int LANES = lenet_pkg::LANES,
  parameter int WIN   = lenet_pkg::WIN
);

  logic                      max_en;
  logic [LANES*WIN*DW-1:0]   fm_bram_1_douta;
  logic [LANES*DW-1:0]       pool_max_result;
  logic                      pool_max_vld;
  logic [3:0]                pool_max_cnt;

  modport master (
    output max_en,
    output fm_bram_1_douta,
    input  pool_max_result,
    input  pool_max_vld,
    input  pool_max_cnt
  );

  modport slave (
    input  max_en,
    input  fm_bram_1_douta,
    output pool_max_result,
    output pool_max_vld,
    output pool_max_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pool_max_1_max4_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : max4_lane                                                        |
// | Purpose : One lane of the 2x2 max-pool: S1 captures the four window        |
// |           samples, S2 forms two pairwise maxima, S3 forms the final max    |
// |           (optionally ReLU-clamped) and holds it until the next update.    |
// | Ports   : clk, rst  clock / synchronous active-high reset                  |
// |           ld_i      capture win_i into S1                                  |
// |           upd_i     S2 holds a valid beat; write S3                        |
// |           win_i     four DW-bit samples, sample k at [k*DW +: DW]          |
// |           res_o     registered pooled sample                               |
// | Config  : POOL_MAX_1_RELU_EN - clamp negative maxima to zero               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module max4_lane #(
  parameter int DW = lenet_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_i,
  input  logic            upd_i,
  input  logic [4*DW-1:0] win_i,
  output logic [DW-1:0]   res_o
);

  logic signed [DW-1:0] w_q [4];
  logic signed [DW-1:0] m0_q, m1_q, res_q;
  logic signed [DW-1:0] m0_d, m1_d, top_d, res_d;

  // On a tie either operand is the same value, so the operand choice is invisible.
  always_comb begin
    m0_d  = (w_q[0] >= w_q[1]) ? w_q[0] : w_q[1];
    m1_d  = (w_q[2] >= w_q[3]) ? w_q[2] : w_q[3];
    top_d = (m0_q >= m1_q) ? m0_q : m1_q;
`ifdef POOL_MAX_1_RELU_EN
    res_d = top_d[DW-1] ? '0 : top_d;
`else
    res_d = top_d;
`endif
  end

  // S2 loads every cycle; only the S3 write is qualified, so stale S1/S2
  // contents never reach the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) w_q[k] <= '0;
      m0_q  <= '0;
      m1_q  <= '0;
      res_q <= '0;
    end else begin
      if (ld_i) begin
        for (int k = 0; k < 4; k++) w_q[k] <= win_i[k*DW +: DW];
      end
      m0_q <= m0_d;
      m1_q <= m1_d;
      if (upd_i) res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule
`default_nettype wire

// File: rtl/pool_max_1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pool_max_1                                                       |
// | Purpose : Three-stage pipelined 2x2 max-pooling of a 40-word row into 10   |
// |           words, one beat per cycle, fixed latency POOL_LAT.               |
// | Ports   : clk, rst  clock / synchronous active-high reset                  |
// |           bus       pool_max_1_if.slave (max_en, fm_bram_1_douta in;       |
// |                     pool_max_result, pool_max_vld, pool_max_cnt out)       |
// | Config  : POOL_MAX_1_RELU_EN - ReLU on each pooled word (in max4_lane)     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pool_max_1 #(
  parameter int DW    = lenet_pkg::DW,
  parameter int LANES = lenet_pkg::LANES,
  parameter int WIN   = lenet_pkg::WIN
) (
  input  logic        clk,
  input  logic        rst,
  pool_max_1_if.slave bus
);

  import lenet_pkg::*;

  logic [POOL_LAT-1:0] vld_q, vld_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [LANES*DW-1:0] lane_res;

  // vld_q[0]: S1 holds a beat, vld_q[1]: S2, vld_q[2]: result register.
  always_comb begin
    vld_d = {vld_q[POOL_LAT-2:0], bus.max_en};
    cnt_d = cnt_q;
    // Counted on the edge that raises pool_max_vld so the count already
    // includes the beat being presented.
    if (vld_q[POOL_LAT-2] && (cnt_q != 4'hF)) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    max4_lane #(.DW(DW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .ld_i  (bus.max_en),
      .upd_i (vld_q[POOL_LAT-2]),
      .win_i (bus.fm_bram_1_douta[l*WIN*DW +: WIN*DW]),
      .res_o (lane_res[l*DW +: DW])
    );
  end

  assign bus.pool_max_result = lane_res;
  assign bus.pool_max_vld    = vld_q[POOL_LAT-1];
  assign bus.pool_max_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_max_1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pool_max_1                                                    |
// | Purpose : Directed scoreboard bench for pool_max_1. Stimulus pushes the    |
// |           hand-computed result, count and arrival cycle; a monitor pops    |
// |           and compares whenever pool_max_vld is seen.                      |
// | Config  : honours POOL_MAX_1_RELU_EN for the negative-lane expectation     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pool_max_1;
  import lenet_pkg::*;

  localparam int RW = LANES*DW;
  localparam int IW = LANES*WIN*DW;

  typedef struct {
    logic [RW-1:0] res;
    logic [3:0]    cnt;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   tb_cnt = 0;
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_max_1_if bus ();

  pool_max_1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] row_all(input logic [15:0] a, b, c, d);
    logic [IW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*WIN*DW +: WIN*DW] = {d, c, b, a};
    return r;
  endfunction

  function automatic logic [RW-1:0] res_all(input logic [15:0] v);
    logic [RW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  // Drive one beat on the next falling edge; its result must appear three
  // rising edges later.
  task automatic issue(input logic [IW-1:0] row, input logic [RW-1:0] exp_res);
    exp_t e;
    @(negedge clk);
    bus.max_en          = 1'b1;
    bus.fm_bram_1_douta = row;
    if (tb_cnt < 15) tb_cnt++;
    e.res = exp_res;
    e.cnt = tb_cnt[3:0];
    e.cyc = cyc + 3;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.max_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    bus.max_en = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    tb_cnt = 0;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pool_max_vld === 1'b1) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_vld: got vld=1 at cycle %0d expected no result", cyc);
        end else begin
          e = sbq.pop_front();
          chk("result", bus.pool_max_result, e.res);
          chk("cnt", RW'(bus.pool_max_cnt), RW'(e.cnt));
          chk("latency_cycle", RW'(cyc), RW'(e.cyc));
        end
      end
    end
  end

  initial begin
    logic [IW-1:0] row;
    logic [RW-1:0] er;
    rst                 = 1'b1;
    bus.max_en          = 1'b0;
    bus.fm_bram_1_douta = '0;
    do_reset();

    // Reset state.
    chk("reset_result", bus.pool_max_result, '0);
    chk("reset_vld", RW'(bus.pool_max_vld), '0);
    chk("reset_cnt", RW'(bus.pool_max_cnt), '0);

    // Single beat then separated pattern beats.
    issue(row_all(16'd1, 16'd7, 16'd3, 16'd5), res_all(16'h0007));
    idle(4);

    row = row_all(16'd1, 16'd2, 16'd3, 16'd4);
    row[0 +: 64] = {16'hFFF5, 16'hFFFE, 16'hFFF8, 16'hFFF0};
    er = res_all(16'h0004);
`ifdef POOL_MAX_1_RELU_EN
    er[0 +: 16] = 16'h0000;
`else
    er[0 +: 16] = 16'hFFFE;
`endif
    issue(row, er);
    issue(row_all(16'h0004, 16'h0004, 16'h0004, 16'h0004), res_all(16'h0004));
    issue(row_all(16'h7FFF, 16'h8000, 16'h0000, 16'h0001), res_all(16'h7FFF));
    idle(6);
    chk("drain_after_patterns", RW'(sbq.size()), '0);

    // Eleven back-to-back beats, w3 = beat index, others -1.
    do_reset();
    for (int b = 0; b < 11; b++)
      issue(row_all(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'(b)), res_all(16'(b)));
    idle(6);
    chk("drain_after_burst", RW'(sbq.size()), '0);
    chk("burst_cnt", RW'(bus.pool_max_cnt), RW'(4'd11));

    // Reset one cycle after a beat: the beat must vanish.
    do_reset();
    @(negedge clk);
    bus.max_en          = 1'b1;
    bus.fm_bram_1_douta = row_all(16'd1, 16'd7, 16'd3, 16'd5);
    @(negedge clk);
    bus.max_en = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    chk("midreset_result", bus.pool_max_result, '0);
    chk("midreset_cnt", RW'(bus.pool_max_cnt), '0);

    // Twenty beats saturate the count; idle afterwards holds the result.
    for (int b = 0; b < 20; b++)
      issue(row_all(16'(b), 16'h0000, 16'h0000, 16'h0000), res_all(16'(b)));
    idle(3);
    chk("sat_cnt", RW'(bus.pool_max_cnt), RW'(4'd15));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", bus.pool_max_result, res_all(16'd19));
      chk("hold_vld", RW'(bus.pool_max_vld), '0);
    end
    chk("drain_final", RW'(sbq.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
